// File: rtl/pulse_width_generator_pkg.sv
// Shared types and width-clamping helper for the bounded-width pulse generator.
// Imported by the generator top; the interface file is type-independent.
package pulse_width_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } pw_state_e;

    typedef struct packed {
        logic [31:0] width;
        logic        out_of_range;
    } clamp_res_t;

    // Clamp a requested width into [lo, hi] and report whether it had to be moved.
    function automatic clamp_res_t clamp_width(input int unsigned value,
                                               input int unsigned lo,
                                               input int unsigned hi);
        clamp_res_t res;
        res.out_of_range = (value < lo) || (value > hi);
        if (value < lo) begin
            res.width = lo;
        end else if (value > hi) begin
            res.width = hi;
        end else begin
            res.width = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/pulse_width_generator_if.sv
// Request/pulse bundle between a pulse requester (master) and the generator (slave).
interface pulse_width_generator_if #(
    parameter int CNT_W = 1
);
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] width_req;
    logic             expr;
    logic             busy;
    logic             done;
    logic             clamped;

    modport master (
        output start_valid,
        output width_req,
        input  start_ready,
        input  expr,
        input  busy,
        input  done,
        input  clamped
    );

    modport slave (
        input  start_valid,
        input  width_req,
        output start_ready,
        output expr,
        output busy,
        output done,
        output clamped
    );
endinterface

// File: rtl/pulse_width_generator.sv
// Bounded-width pulse generator: emits one pulse of clamp(width_req) cycles per accepted request,
// followed by GAP_CKS forced low cycles. Define PULSE_WIDTH_GENERATOR_ASSERT_EN for embedded SVA/covers.
//
// state | meaning
// IDLE  | ready for a request, expr low
// HIGH  | expr high, counter counts down remaining high cycles
// GAP   | expr low, counter counts down remaining gap cycles
module pulse_width_generator
    import pulse_width_pkg::*;
#(
    parameter int unsigned MIN_CKS = 1,
    parameter int unsigned MAX_CKS = 1,
    parameter int unsigned GAP_CKS = 1,
    parameter int          CNT_W   = $clog2(MAX_CKS + 1)
) (
    input  logic clk,
    input  logic reset,
    pulse_width_generator_if.slave bus
);

    // One counter serves both phases, so it must hold the larger of the two reload values.
    localparam int GAP_W = $clog2(GAP_CKS + 1);
    localparam int CTR_W = (GAP_W > CNT_W) ? GAP_W : CNT_W;

    pw_state_e  state, state_nxt;
    logic [CTR_W-1:0] cnt, cnt_nxt;
    logic       expr_q, expr_nxt;
    logic       done_q, done_nxt;
    logic       clamped_q, clamped_nxt;
    logic       accept;
    clamp_res_t cres;

    assign accept = (state == IDLE) && bus.start_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            expr_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            expr_q    <= expr_nxt;
            done_q    <= done_nxt;
            clamped_q <= clamped_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        expr_nxt    = 1'b0;
        done_nxt    = 1'b0;
        clamped_nxt = 1'b0;
        cres        = clamp_width(32'(bus.width_req), MIN_CKS, MAX_CKS);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = HIGH;
                    cnt_nxt     = CTR_W'(cres.width - 32'd1);
                    expr_nxt    = 1'b1;
                    clamped_nxt = cres.out_of_range;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = CTR_W'(GAP_CKS - 1);
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt - 1'b1;
                    expr_nxt = 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.expr        = expr_q;
    assign bus.done        = done_q;
    assign bus.clamped     = clamped_q;

`ifdef PULSE_WIDTH_GENERATOR_ASSERT_EN
    logic [CNT_W-1:0] w_latched;
    logic [CNT_W:0]   run_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_latched <= '0;
            run_len   <= '0;
        end else begin
            if (accept) begin
                w_latched <= CNT_W'(cres.width);
            end
            run_len <= expr_q ? run_len + 1'b1 : '0;
        end
    end

    // run_len holds the number of high cycles seen before the current sample.
    a_run_not_over: assert property (@(posedge clk) disable iff (reset)
        expr_q |-> (run_len < {1'b0, w_latched}));

    a_run_exact: assert property (@(posedge clk) disable iff (reset)
        ($fell(expr_q) && !$past(reset)) |-> (run_len == {1'b0, w_latched}));

    a_run_bounds: assert property (@(posedge clk) disable iff (reset)
        ($fell(expr_q) && !$past(reset)) |->
            ((32'(run_len) >= MIN_CKS) && (32'(run_len) <= MAX_CKS)));

    a_ready_low: assert property (@(posedge clk) disable iff (reset)
        bus.start_ready |-> !expr_q);

    c_min_pulse: cover property (@(posedge clk) disable iff (reset)
        $fell(expr_q) && !$past(reset) && (32'(run_len) == MIN_CKS));

    c_max_pulse: cover property (@(posedge clk) disable iff (reset)
        $fell(expr_q) && !$past(reset) && (32'(run_len) == MAX_CKS));

    c_clamped: cover property (@(posedge clk) disable iff (reset)
        clamped_q);
`endif

endmodule

// File: tb/tb_pulse_width_generator.sv
// Self-checking bench for pulse_width_generator (MIN=2, MAX=5, GAP=1): timeline model plus directed traces.
module tb_pulse_width_generator;

    localparam int unsigned MIN  = 2;
    localparam int unsigned MAX  = 5;
    localparam int unsigned GAPC = 1;
    localparam int          CW   = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic reset;

    pulse_width_generator_if #(.CNT_W(CW)) pif ();

    pulse_width_generator #(
        .MIN_CKS(MIN),
        .MAX_CKS(MAX),
        .GAP_CKS(GAPC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (pif.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model: the latest accepted pulse is described by its start cycle, width and clamp flag.
    int cyc = 0;
    bit pv = 0;
    int ps = 0;
    int pw = 0;
    bit poor = 0;
    bit chk_en = 0;

    function automatic bit in_pulse(input int c);
        return pv && (c >= ps) && (c < ps + pw);
    endfunction

    function automatic bit in_busy(input int c);
        return pv && (c >= ps) && (c < ps + pw + int'(GAPC));
    endfunction

    always @(posedge clk) begin
        int r;
        r = int'(pif.width_req);
        if (reset) begin
            pv = 0;
        end else if (pif.start_valid && !in_busy(cyc)) begin
            pv   = 1;
            ps   = cyc + 1;
            pw   = (r < int'(MIN)) ? int'(MIN) : (r > int'(MAX)) ? int'(MAX) : r;
            poor = (r < int'(MIN)) || (r > int'(MAX));
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("expr",        int'(pif.expr),        int'(in_pulse(cyc)));
            chk("busy",        int'(pif.busy),        int'(in_busy(cyc)));
            chk("start_ready", int'(pif.start_ready), int'(!in_busy(cyc)));
            chk("done",        int'(pif.done),        int'(pv && cyc == ps + pw));
            chk("clamped",     int'(pif.clamped),     int'(pv && poor && cyc == ps));
        end
    end

    task automatic pulse_trace(input int req, input int n, input bit hold,
                               output bit [15:0] ex, output bit [15:0] dn,
                               output bit [15:0] cl, output bit [15:0] rd);
        ex = '0; dn = '0; cl = '0; rd = '0;
        pif.start_valid = 1'b1;
        pif.width_req   = CW'(req);
        @(negedge clk);
        if (!hold) pif.start_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            ex[i] = pif.expr;
            dn[i] = pif.done;
            cl[i] = pif.clamped;
            rd[i] = pif.start_ready;
            @(negedge clk);
        end
        pif.start_valid = 1'b0;
    endtask

    bit [15:0] ex, dn, cl, rd;
    int done_cnt;

    initial begin
        reset           = 1'b1;
        pif.start_valid = 1'b0;
        pif.width_req   = '0;
        repeat (3) @(negedge clk);
        chk("rst_expr",    int'(pif.expr),        0);
        chk("rst_busy",    int'(pif.busy),        0);
        chk("rst_done",    int'(pif.done),        0);
        chk("rst_clamped", int'(pif.clamped),     0);
        chk("rst_ready",   int'(pif.start_ready), 1);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        pulse_trace(3, 10, 1'b0, ex, dn, cl, rd);
        chk("w3_expr", int'(ex), 'h007);
        chk("w3_done", int'(dn), 'h008);
        chk("w3_clamp", int'(cl), 'h000);
        repeat (3) @(negedge clk);

        pulse_trace(0, 10, 1'b0, ex, dn, cl, rd);
        chk("w0_expr", int'(ex), 'h003);
        chk("w0_done", int'(dn), 'h004);
        chk("w0_clamp", int'(cl), 'h001);
        repeat (3) @(negedge clk);

        pulse_trace(7, 10, 1'b0, ex, dn, cl, rd);
        chk("w7_expr", int'(ex), 'h01F);
        chk("w7_done", int'(dn), 'h020);
        chk("w7_clamp", int'(cl), 'h001);
        repeat (3) @(negedge clk);

        pulse_trace(2, 12, 1'b1, ex, dn, cl, rd);
        chk("hold_expr", int'(ex), 'h333);
        chk("hold_ready", int'(rd), 'h888);
        chk("hold_done", int'(dn), 'h444);
        repeat (6) @(negedge clk);

        // Request arriving while HIGH must be ignored.
        pif.start_valid = 1'b1;
        pif.width_req   = CW'(3);
        @(negedge clk);
        pif.width_req   = CW'(5);
        ex = '0;
        for (int i = 0; i < 10; i++) begin
            ex[i] = pif.expr;
            if (i == 2) pif.start_valid = 1'b0;
            @(negedge clk);
        end
        chk("busy_req_expr", int'(ex), 'h007);
        repeat (3) @(negedge clk);

        // Reset on the second high cycle of a 4-wide pulse.
        pif.start_valid = 1'b1;
        pif.width_req   = CW'(4);
        @(negedge clk);
        pif.start_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_expr", int'(pif.expr), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_expr", int'(pif.expr), 0);
        chk("abort_busy", int'(pif.busy), 0);
        reset    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            done_cnt += int'(pif.done);
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);
        pulse_trace(4, 10, 1'b0, ex, dn, cl, rd);
        chk("after_abort_expr", int'(ex), 'h00F);
        chk("after_abort_done", int'(dn), 'h010);
        repeat (3) @(negedge clk);

        // Reset and request together: reset wins.
        reset           = 1'b1;
        pif.start_valid = 1'b1;
        pif.width_req   = CW'(3);
        @(negedge clk);
        chk("rst_vs_req_busy", int'(pif.busy), 0);
        chk("rst_vs_req_expr", int'(pif.expr), 0);
        reset           = 1'b0;
        pif.start_valid = 1'b0;
        @(negedge clk);
        chk("rst_vs_req_after", int'(pif.busy), 0);

        for (int i = 0; i < 3000; i++) begin
            pif.start_valid = ($urandom_range(0, 3) == 0);
            pif.width_req   = CW'($urandom_range(0, 7));
            reset           = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        reset           = 1'b0;
        pif.start_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
